// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with write-first bypass and scrub engine
// Optional feature macro: REGFILE_REG0_ZERO_EN (entry 0 hardwired to zero).
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     scrub_req,
    output logic                     busy,
    output logic                     scrub_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCRUB = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_ok;
    logic [DATA_W-1:0]   rd_word [NUM_RD];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (scrub_req) state_nxt = SCRUB;
            SCRUB:   if (cnt == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so they behave as registered flags.
    always_comb begin
        busy       = (state == SCRUB);
        scrub_done = (state == DONE);
    end

    // Counter sits at zero outside SCRUB, which gives the load-0 on entry for free.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (busy && cnt != LAST_IDX) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_comb begin
        wr_ok = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_EXT);
`ifdef REGFILE_REG0_ZERO_EN
        if (wr_addr == '0) wr_ok = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (busy && cnt == ADDR_W'(e)) begin
                    mem[e] <= '0;
                end else if (wr_ok && wr_addr == ADDR_W'(e)) begin
                    mem[e] <= wr_data;
                end
            end
        end
    end

    // Out-of-range addresses match no entry and fall through to zero.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_word[i] = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(e)) rd_word[i] = mem[e];
            end
            if (wr_ok && wr_addr == rd_addr[i*ADDR_W +: ADDR_W]) rd_word[i] = wr_data;
            if (busy) rd_word[i] = '0;
`ifdef REGFILE_REG0_ZERO_EN
            if (rd_addr[i*ADDR_W +: ADDR_W] == '0) rd_word[i] = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) rd_data[i*DATA_W +: DATA_W] <= rd_word[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
`ifdef REGFILE_REG0_ZERO_EN
    localparam bit Z0 = 1'b1;
`else
    localparam bit Z0 = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clr_n;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_valid;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              scrub_req;
    logic              busy;
    logic              scrub_done;

    logic              s_rd_en;
    logic [AW-1:0]     s_rd_addr;
    logic [DW-1:0]     s_rd_data;
    logic              s_rd_valid;
    logic              s_wr_en;
    logic [AW-1:0]     s_wr_addr;
    logic [DW-1:0]     s_wr_data;
    logic              s_scrub_req;
    logic              s_busy;
    logic              s_scrub_done;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .NUM_RD(NR)) u_dut (
        .clk(clk), .clr_n(clr_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scrub_req(scrub_req), .busy(busy), .scrub_done(scrub_done)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(20), .NUM_RD(1)) u_small (
        .clk(clk), .clr_n(clr_n), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .scrub_req(s_scrub_req), .busy(s_busy), .scrub_done(s_scrub_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [32];
    bit            in_scrub;
    int            n_assert = 0;
    int            n_fail = 0;
    int            busy_cycles;
    int            done_pulses;
    int            guard;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_wr(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        if (!in_scrub && !(Z0 && addr == 0)) model[addr] = data;
    endtask

    task automatic drive_rd(input int port, input int addr);
        exp_t e;
        rd_en[port] = 1'b1;
        rd_addr[port*AW +: AW] = AW'(addr);
        e.port = port;
        e.data = in_scrub ? '0 : model[addr];
        sb.push_back(e);
    endtask

    task automatic tick();
        logic [NR-1:0] en_s;
        int idx;
        en_s = rd_en;
        @(posedge clk);
        #1;
        if (busy) busy_cycles++;
        if (scrub_done) done_pulses++;
        for (int p = 0; p < NR; p++) begin
            if (en_s[p]) begin
                idx = -1;
                foreach (sb[k]) if (idx < 0 && sb[k].port == p) idx = k;
                if (idx < 0) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL sb_missing: observed no expectation for port %0d expected one", p);
                end else begin
                    chk($sformatf("rd_valid_p%0d", p), 64'(rd_valid[p]), 64'd1);
                    chk($sformatf("rd_data_p%0d", p), 64'(rd_data[p*DW +: DW]), 64'(sb[idx].data));
                    sb.delete(idx);
                end
            end else begin
                chk($sformatf("rd_idle_p%0d", p), 64'(rd_valid[p]), 64'd0);
            end
        end
        rd_en     = '0;
        wr_en     = 1'b0;
        scrub_req = 1'b0;
        s_rd_en   = 1'b0;
        s_wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        scrub_req = 1'b0; s_rd_en = 1'b0; s_rd_addr = '0; s_wr_en = 1'b0; s_wr_addr = '0;
        s_wr_data = '0; s_scrub_req = 1'b0; in_scrub = 1'b0; busy_cycles = 0; done_pulses = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        tick();
        tick();
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_scrub_done", 64'(scrub_done), 64'd0);
        clr_n = 1'b1;

        drive_rd(0, 3); drive_rd(1, 7); tick();
        chk("reset_read_valid", 64'(rd_valid), 64'd3);
        chk("reset_read_data", rd_data, 64'd0);

        drive_wr(9, 32'hDEADBEEF); tick();
        drive_rd(1, 9); tick();
        chk("write_read_valid", 64'(rd_valid), 64'd2);
        chk("write_read_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);

        drive_rd(0, 9); tick();
        drive_rd(1, 3); tick();
        chk("hold_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);

        drive_wr(12, 32'h0BAD0BAD); tick();
        drive_wr(12, 32'h12345678); drive_rd(0, 12); drive_rd(1, 12); tick();
        chk("bypass_p0", 64'(rd_data[31:0]), 64'h12345678);
        tick();
        chk("hold_p1", 64'(rd_data[63:32]), 64'h12345678);

        drive_wr(0, 32'hA5A5A5A5); drive_rd(0, 0); tick();
        chk("reg0_bypass", 64'(rd_data[31:0]), Z0 ? 64'd0 : 64'hA5A5A5A5);
        drive_rd(1, 0); tick();

        s_wr_en = 1'b1; s_wr_addr = 5'd25; s_wr_data = 32'h77; tick();
        s_wr_en = 1'b1; s_wr_addr = 5'd19; s_wr_data = 32'h1919; tick();
        s_rd_en = 1'b1; s_rd_addr = 5'd25; tick();
        chk("oor_data", 64'(s_rd_data), 64'd0);
        chk("oor_valid", 64'(s_rd_valid), 64'd1);
        s_rd_en = 1'b1; s_rd_addr = 5'd19; tick();
        chk("last_entry_small", 64'(s_rd_data), 64'h1919);

        for (int a = 0; a < 32; a++) begin
            drive_wr(a, DW'(a + 1)); tick();
        end
        for (int a = 0; a < 32; a += 2) begin
            drive_rd(0, a); drive_rd(1, a + 1); tick();
        end

        busy_cycles = 0; done_pulses = 0;
        scrub_req = 1'b1; in_scrub = 1'b1; tick();
        guard = 0;
        while (busy && guard < 100) begin
            if (busy_cycles == 10) begin
                drive_wr(5, 32'hFFFF);
                drive_rd(0, 5);
            end
            scrub_req = 1'b1;
            tick();
            guard++;
        end
        in_scrub = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick();
        chk("scrub_busy_cycles", 64'(busy_cycles), 64'd32);
        chk("scrub_done_pulses", 64'(done_pulses), 64'd1);
        for (int a = 0; a < 32; a += 2) begin
            drive_rd(0, a); drive_rd(1, a + 1); tick();
        end
        drive_rd(0, 5); tick();
        chk("addr5_not_written", 64'(rd_data[31:0]), 64'd0);

        drive_wr(3, 32'h33); tick();
        busy_cycles = 0;
        scrub_req = 1'b1; in_scrub = 1'b1; tick();
        repeat (9) tick();
        chk("mid_scrub_cycle", 64'(busy_cycles), 64'd10);
        chk("mid_scrub_busy", 64'(busy), 64'd1);
        clr_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_scrub_done", 64'(scrub_done), 64'd0);
        chk("abort_rd_valid", 64'(rd_valid), 64'd0);
        in_scrub = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick();
        clr_n = 1'b1;
        drive_rd(0, 3); tick();
        drive_wr(4, 32'h44); tick();
        drive_rd(1, 4); tick();
        chk("post_abort_write", 64'(rd_data[63:32]), 64'h44);
        chk("small_busy", 64'(s_busy), 64'd0);
        chk("small_scrub_done", 64'(s_scrub_done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
